// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one single-ported SRAM between two req/ack masters.
// Each granted request runs IDLE -> ACCESS -> COMPLETE. sram_en is low for
// exactly the ACCESS cycle. ack pulses and read data is captured in COMPLETE.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   mX_req/we/addr/wdata  request from master X (0 = control unit, 1 = secondary)
//   mX_ack, mX_rdata      one-cycle completion pulse, registered read data
//   sram_en, write_en     SRAM controls (active-low enable; 0 = write, 1 = read)
//   sram_addr/wdata/rdata SRAM address, write data and read data
//   busy, gnt_id          access in flight; port owning the current/last access
//
// Build option: define SRAM_ARB_RR_EN for round-robin arbitration on
// contention. When it is undefined, port 0 has fixed priority.
module sram_arbiter #(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
  output logic          sram_en,
  output logic          write_en,
  output logic [AW-1:0] sram_addr,
  output logic [DW-1:0] sram_wdata,
  input  logic [DW-1:0] sram_rdata,
  output logic          busy,
  output logic          gnt_id
);

  typedef enum logic [1:0] {IDLE, ACCESS, COMPLETE} state_t;

  state_t        r_state;
  logic          r_sram_en;
  logic          r_write_en;
  logic [AW-1:0] r_sram_addr;
  logic [DW-1:0] r_sram_wdata;
  logic          r_m0_ack;
  logic          r_m1_ack;
  logic [DW-1:0] r_m0_rdata;
  logic [DW-1:0] r_m1_rdata;
  logic          r_busy;
  logic          r_gnt_id;

  logic          w_pick1;
  logic          w_sel_we;
  logic [AW-1:0] w_sel_addr;
  logic [DW-1:0] w_sel_wdata;

`ifdef SRAM_ARB_RR_EN
  // r_last holds the port granted most recently. Its reset value of 1 gives
  // port 0 the first contention after reset.
  logic r_last;
  assign w_pick1 = m1_req & (~m0_req | ~r_last);
`else
  assign w_pick1 = m1_req & ~m0_req;
`endif

  assign w_sel_we    = w_pick1 ? m1_we    : m0_we;
  assign w_sel_addr  = w_pick1 ? m1_addr  : m0_addr;
  assign w_sel_wdata = w_pick1 ? m1_wdata : m0_wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_sram_en    <= 1'b1;
      r_write_en   <= 1'b1;
      r_sram_addr  <= '0;
      r_sram_wdata <= '0;
      r_m0_ack     <= 1'b0;
      r_m1_ack     <= 1'b0;
      r_m0_rdata   <= '0;
      r_m1_rdata   <= '0;
      r_busy       <= 1'b0;
      r_gnt_id     <= 1'b0;
`ifdef SRAM_ARB_RR_EN
      r_last       <= 1'b1;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_m0_ack <= 1'b0;
          r_m1_ack <= 1'b0;
          if (m0_req || m1_req) begin
            r_state      <= ACCESS;
            r_sram_en    <= 1'b0;
            r_write_en   <= ~w_sel_we;
            r_sram_addr  <= w_sel_addr;
            r_sram_wdata <= w_sel_wdata;
            r_gnt_id     <= w_pick1;
            r_busy       <= 1'b1;
`ifdef SRAM_ARB_RR_EN
            r_last       <= w_pick1;
`endif
          end
        end
        ACCESS: begin
          r_state    <= COMPLETE;
          r_sram_en  <= 1'b1;
          r_write_en <= 1'b1;
          // r_write_en still holds the direction of the access that just ran.
          if (r_write_en) begin
            if (r_gnt_id) r_m1_rdata <= sram_rdata;
            else          r_m0_rdata <= sram_rdata;
          end
          r_m0_ack <= ~r_gnt_id;
          r_m1_ack <= r_gnt_id;
        end
        COMPLETE: begin
          r_state  <= IDLE;
          r_m0_ack <= 1'b0;
          r_m1_ack <= 1'b0;
          r_busy   <= 1'b0;
        end
        default: begin
          r_state   <= IDLE;
          r_sram_en <= 1'b1;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign sram_en    = r_sram_en;
  assign write_en   = r_write_en;
  assign sram_addr  = r_sram_addr;
  assign sram_wdata = r_sram_wdata;
  assign m0_ack     = r_m0_ack;
  assign m1_ack     = r_m1_ack;
  assign m0_rdata   = r_m0_rdata;
  assign m1_rdata   = r_m1_rdata;
  assign busy       = r_busy;
  assign gnt_id     = r_gnt_id;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed bench for sram_arbiter.
// It contains a 256 x 16 SRAM model with asynchronous read and a synchronous
// write that happens when sram_en and write_en are both low.
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [7:0]  m0_addr, m1_addr;
  logic [15:0] m0_wdata, m1_wdata;
  logic        m0_ack, m1_ack;
  logic [15:0] m0_rdata, m1_rdata;
  logic        sram_en, write_en;
  logic [7:0]  sram_addr;
  logic [15:0] sram_wdata, sram_rdata;
  logic        busy, gnt_id;

  logic [15:0] mem [0:255];
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  sram_arbiter #(.AW(8), .DW(16)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .sram_en(sram_en), .write_en(write_en), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .busy(busy), .gnt_id(gnt_id)
  );

  assign sram_rdata = mem[sram_addr];
  always @(posedge clk)
    if (!sram_en && !write_en) mem[sram_addr] <= sram_wdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input bit p, input bit r, input bit we,
                       input logic [7:0] a, input logic [15:0] d);
    if (!p) begin m0_req = r; m0_we = we; m0_addr = a; m0_wdata = d; end
    else    begin m1_req = r; m1_we = we; m1_addr = a; m1_wdata = d; end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".sram_en"}, sram_en, 1);
    check({tag, ".write_en"}, write_en, 1);
    check({tag, ".sram_addr"}, sram_addr, 0);
    check({tag, ".sram_wdata"}, sram_wdata, 0);
    check({tag, ".m0_ack"}, m0_ack, 0);
    check({tag, ".m1_ack"}, m1_ack, 0);
    check({tag, ".m0_rdata"}, m0_rdata, 0);
    check({tag, ".m1_rdata"}, m1_rdata, 0);
    check({tag, ".busy"}, busy, 0);
    check({tag, ".gnt_id"}, gnt_id, 0);
  endtask

  // Runs one uncontended access and checks each of its three cycles.
  task automatic do_access(input string tag, input bit p, input bit we,
                           input logic [7:0] a, input logic [15:0] d,
                           input logic [15:0] exp0, input logic [15:0] exp1);
    drive(p, 1'b1, we, a, d);
    tick;
    check({tag, ".acc_en"}, sram_en, 0);
    check({tag, ".acc_we"}, write_en, !we);
    check({tag, ".acc_addr"}, sram_addr, a);
    check({tag, ".acc_wdata"}, sram_wdata, d);
    check({tag, ".acc_busy"}, busy, 1);
    check({tag, ".acc_gnt"}, gnt_id, p);
    check({tag, ".acc_noack"}, {m1_ack, m0_ack}, 0);
    tick;
    check({tag, ".cmp_en"}, sram_en, 1);
    check({tag, ".cmp_we"}, write_en, 1);
    check({tag, ".cmp_ack"}, {m1_ack, m0_ack}, p ? 2'b10 : 2'b01);
    check({tag, ".cmp_rd0"}, m0_rdata, exp0);
    check({tag, ".cmp_rd1"}, m1_rdata, exp1);
    drive(p, 1'b0, we, a, d);
    tick;
    check({tag, ".idle_ack"}, {m1_ack, m0_ack}, 0);
    check({tag, ".idle_busy"}, busy, 0);
    check({tag, ".idle_en"}, sram_en, 1);
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000);
    tick;
    tick;
    check_reset_outputs("rst");
    reset = 1'b0;
    tick;
    check_reset_outputs("post_rst");

    // Port 0 writes, then port 1 reads the word back.
    do_access("wr0", 1'b0, 1'b1, 8'h10, 16'hBEEF, 16'h0000, 16'h0000);
    do_access("rd1", 1'b1, 1'b0, 8'h10, 16'h0000, 16'h0000, 16'hBEEF);

    // Port 0 keeps req high one cycle past ack, so a second access starts.
    drive(1'b0, 1'b1, 1'b0, 8'h10, 16'h0000);
    tick;
    check("hold.acc1_en", sram_en, 0);
    tick;
    check("hold.ack1", m0_ack, 1);
    check("hold.rd1", m0_rdata, 16'hBEEF);
    tick;
    check("hold.gap_ack", m0_ack, 0);
    tick;
    check("hold.acc2_en", sram_en, 0);
    check("hold.acc2_addr", sram_addr, 8'h10);
    tick;
    check("hold.ack2", m0_ack, 1);
    check("hold.rd1_keep", m1_rdata, 16'hBEEF);
    drive(1'b0, 1'b0, 1'b0, 8'h10, 16'h0000);
    tick;
    tick;
    check("hold.quiet_busy", busy, 0);
    check("hold.quiet_en", sram_en, 1);

    // Preload through the arbiter. Writes must not disturb either rdata.
    do_access("pre40", 1'b0, 1'b1, 8'h40, 16'h1111, 16'hBEEF, 16'hBEEF);
    do_access("pre41", 1'b1, 1'b1, 8'h41, 16'h2222, 16'hBEEF, 16'hBEEF);
    do_access("pre20", 1'b0, 1'b1, 8'h20, 16'hA5A5, 16'hBEEF, 16'hBEEF);
    do_access("pre30", 1'b1, 1'b1, 8'h30, 16'h5A5A, 16'hBEEF, 16'hBEEF);

    // Continuous contention on two reads, starting from reset.
    reset = 1'b1;
    tick;
    reset = 1'b0;
    check_reset_outputs("rst2");
    drive(1'b0, 1'b1, 1'b0, 8'h40, 16'h0000);
    drive(1'b1, 1'b1, 1'b0, 8'h41, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      logic exp_g;
`ifdef SRAM_ARB_RR_EN
      exp_g = i[0];
`else
      exp_g = 1'b0;
`endif
      tick;
      check($sformatf("cont%0d.gnt", i), gnt_id, exp_g);
      check($sformatf("cont%0d.en", i), sram_en, 0);
      check($sformatf("cont%0d.addr", i), sram_addr, exp_g ? 8'h41 : 8'h40);
      tick;
      check($sformatf("cont%0d.ack", i), {m1_ack, m0_ack}, exp_g ? 2'b10 : 2'b01);
      if (i == 3) begin
        drive(1'b0, 1'b0, 1'b0, 8'h40, 16'h0000);
        drive(1'b1, 1'b0, 1'b0, 8'h41, 16'h0000);
      end
      tick;
    end
    check("cont.rd0", m0_rdata, 16'h1111);
`ifdef SRAM_ARB_RR_EN
    check("cont.rd1", m1_rdata, 16'h2222);
`else
    check("cont.rd1", m1_rdata, 16'h0000);
`endif
    tick;
    check("cont.idle_busy", busy, 0);

    // Changing the address mid-access has no effect on the access.
    drive(1'b0, 1'b1, 1'b0, 8'h20, 16'h0000);
    tick;
    check("addrchg.acc_addr", sram_addr, 8'h20);
    drive(1'b0, 1'b1, 1'b1, 8'h30, 16'h7777);
    tick;
    check("addrchg.cmp_addr", sram_addr, 8'h20);
    check("addrchg.ack", m0_ack, 1);
    check("addrchg.rd0", m0_rdata, 16'hA5A5);
    drive(1'b0, 1'b0, 1'b0, 8'h30, 16'h0000);
    tick;
    tick;
    check("addrchg.idle_busy", busy, 0);

    // Reset arrives while an access is in flight.
    drive(1'b0, 1'b1, 1'b1, 8'h55, 16'h1234);
    tick;
    check("rstacc.acc_en", sram_en, 0);
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
    tick;
    check_reset_outputs("rstacc");
    reset = 1'b0;
    tick;
    check("rstacc.after_ack", {m1_ack, m0_ack}, 0);
    check("rstacc.after_en", sram_en, 1);
    check("rstacc.after_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
